// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler.
// Holds the scheduler state/phase enums and the tag byte builder.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        ACK   = 2'd2,
        DRAIN = 2'd3
    } sched_state_t;

    typedef enum logic {
        PH_TAG  = 1'b0,
        PH_DATA = 1'b1
    } phase_t;

    localparam logic [3:0] TAG_MARK_DEFAULT = 4'hA;

    function automatic logic [7:0] make_tag(input logic [3:0] mark, input logic [3:0] id);
        return {mark, id};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
// Reports the winning index and whether any request is pending.
module rr_arbiter #(
    parameter int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any_req
);

    localparam int DBL_W = $clog2(2 * N_REQ);

    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   rot;
    logic [IDX_W-1:0]   offset;
    logic [IDX_W:0]     sum;

    assign req_dbl = {req, req};
    assign any_req = |req;

    // rot[k] is the request k positions above ptr, wrapping via the doubled vector
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
            logic [DBL_W-1:0] rot_idx;
            assign rot_idx = DBL_W'(ptr) + DBL_W'(gi);
            assign rot[gi] = req_dbl[rot_idx];
        end
    endgenerate

    always_comb begin
        offset = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                offset = IDX_W'(i);
            end
        end
        sum = {1'b0, ptr} + {1'b0, offset};
        if (sum >= (IDX_W + 1)'(N_REQ)) begin
            sum = sum - (IDX_W + 1)'(N_REQ);
        end
        grant_idx = sum[IDX_W-1:0];
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin burst scheduler sharing one UART serializer among N_REQ byte sources.
// Optional tag byte precedes each burst; a missing busy acknowledge raises a sticky error.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int         N_REQ       = 4,
    parameter int         MAX_BURST   = 8,
    parameter bit         TAG_EN      = 1'b1,
    parameter logic [3:0] TAG_MARK    = TAG_MARK_DEFAULT,
    parameter int         ACK_TIMEOUT = 4,
    localparam int        IDX_W       = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*8-1:0] req_data,
    output logic [N_REQ-1:0]   req_ready,
    output logic               tx_start,
    output logic [7:0]         tx_data,
    input  logic               tx_busy,
    output logic               grant_active,
    output logic [IDX_W-1:0]   grant_id,
    output logic               err_timeout
);

    localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);

    sched_state_t     state_q, state_d;
    phase_t           phase_q, phase_d;
    logic [7:0]       burst_cnt_q, burst_cnt_d;
    logic [ACK_W-1:0] ack_cnt_q, ack_cnt_d;
    logic [ACK_W-1:0] ack_inc;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] grant_id_q, grant_id_d;
    logic             grant_active_q, grant_active_d;
    logic             err_timeout_q, err_timeout_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic [N_REQ-1:0] req_ready_d;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_any;
    logic [IDX_W-1:0] next_ptr;

    rr_arbiter #(
        .N_REQ(N_REQ)
    ) u_arb (
        .req      (req_valid),
        .ptr      (rr_ptr_q),
        .grant_idx(arb_idx),
        .any_req  (arb_any)
    );

    assign next_ptr = (grant_id_q == IDX_W'(N_REQ - 1)) ? '0 : grant_id_q + 1'b1;
    assign ack_inc  = ack_cnt_q + 1'b1;

    always_comb begin
        state_d        = state_q;
        phase_d        = phase_q;
        burst_cnt_d    = burst_cnt_q;
        ack_cnt_d      = ack_cnt_q;
        rr_ptr_d       = rr_ptr_q;
        grant_id_d     = grant_id_q;
        grant_active_d = grant_active_q;
        err_timeout_d  = err_timeout_q;
        tx_data_d      = tx_data_q;
        req_ready_d    = '0;

        unique case (state_q)
            IDLE: begin
                if (arb_any) begin
                    grant_id_d     = arb_idx;
                    grant_active_d = 1'b1;
                    burst_cnt_d    = 8'd0;
                    state_d        = START;
                    if (TAG_EN) begin
                        tx_data_d = make_tag(TAG_MARK, 4'(arb_idx));
                        phase_d   = PH_TAG;
                    end else begin
                        req_ready_d[arb_idx] = 1'b1;
                        tx_data_d            = req_data[{arb_idx, 3'b000} +: 8];
                        phase_d              = PH_DATA;
                        burst_cnt_d          = 8'd1;
                    end
                end
            end
            START: begin
                state_d   = ACK;
                ack_cnt_d = '0;
            end
            ACK: begin
                if (tx_busy) begin
                    state_d = DRAIN;
                end else if (ack_inc == ACK_W'(ACK_TIMEOUT)) begin
                    // Serializer never answered: drop the burst but keep fairness moving
                    err_timeout_d  = 1'b1;
                    grant_active_d = 1'b0;
                    rr_ptr_d       = next_ptr;
                    state_d        = IDLE;
                end else begin
                    ack_cnt_d = ack_inc;
                end
            end
            DRAIN: begin
                if (!tx_busy) begin
                    if ((phase_q == PH_TAG || burst_cnt_q < 8'(MAX_BURST)) && req_valid[grant_id_q]) begin
                        req_ready_d[grant_id_q] = 1'b1;
                        tx_data_d               = req_data[{grant_id_q, 3'b000} +: 8];
                        phase_d                 = PH_DATA;
                        burst_cnt_d             = burst_cnt_q + 8'd1;
                        state_d                 = START;
                    end else begin
                        grant_active_d = 1'b0;
                        rr_ptr_d       = next_ptr;
                        state_d        = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            phase_q        <= PH_TAG;
            burst_cnt_q    <= 8'd0;
            ack_cnt_q      <= '0;
            rr_ptr_q       <= '0;
            grant_id_q     <= '0;
            grant_active_q <= 1'b0;
            err_timeout_q  <= 1'b0;
            tx_data_q      <= 8'd0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            burst_cnt_q    <= burst_cnt_d;
            ack_cnt_q      <= ack_cnt_d;
            rr_ptr_q       <= rr_ptr_d;
            grant_id_q     <= grant_id_d;
            grant_active_q <= grant_active_d;
            err_timeout_q  <= err_timeout_d;
            tx_data_q      <= tx_data_d;
        end
    end

    // Ready is combinational so the handshake lands on the edge that loads tx_data
    assign req_ready    = reset ? '0 : req_ready_d;
    assign tx_start     = (state_q == START);
    assign tx_data      = tx_data_q;
    assign grant_active = grant_active_q;
    assign grant_id     = grant_id_q;
    assign err_timeout  = err_timeout_q;

endmodule
